// File: rtl/id_issue_sb.sv
// rtl/id_issue_sb.sv - decode/issue stage with per-register pending-write counters and ID/EX slot
module id_issue_sb #(
  parameter int                DATA_W    = 16,
  parameter int                NREGS     = 16,
  parameter int                SP_IDX    = 15,
  parameter logic [DATA_W-1:0] SP_RESET  = 16'hFFFF,
  parameter int                MAX_INFL  = 3,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [15:0]       WR_MASK   = 16'h00FF,
  parameter logic [15:0]       RT_MASK   = 16'h000F,
  parameter logic [15:0]       SRC2_RD   = 16'h0100,
  parameter logic [15:0]       IMM8_MASK = 16'h00F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_inst,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [3:0]        out_rd,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic              hazard,
  output logic [15:0]       stall_cnt
);
  localparam int RA_W = $clog2(NREGS);
  localparam int CW   = $clog2(MAX_INFL + 1);

  logic [DATA_W-1:0] regs    [NREGS];
  logic [CW-1:0]     cnt     [NREGS];
  logic [CW-1:0]     cnt_nxt [NREGS];

  logic [3:0]        op, rd, rs, rt, s2;
  logic              wr, src2_used, full, fire;
  logic [DATA_W-1:0] src1_val, src2_val, imm_val;
  logic [CW:0]       up, dn;

  function automatic logic in_range(input logic [3:0] f);
    return {28'd0, f} < 32'(NREGS);
  endfunction

  // A write-back retiring the last outstanding write releases the register this cycle.
  function automatic logic pend(input logic [3:0] f);
    logic [RA_W-1:0] i;
    i = f[RA_W-1:0];
    return in_range(f) && (cnt[i] != '0) &&
           !(BYPASS && wb_en && (wb_reg == f) && (cnt[i] == CW'(1)));
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] f);
    if (!in_range(f)) return '0;
    if (BYPASS && wb_en && (wb_reg == f)) return wb_data;
    return regs[f[RA_W-1:0]];
  endfunction

  assign op        = in_inst[15:12];
  assign rd        = in_inst[11:8];
  assign rs        = in_inst[7:4];
  assign rt        = in_inst[3:0];
  assign wr        = WR_MASK[op];
  assign src2_used = SRC2_RD[op] | RT_MASK[op];
  assign s2        = SRC2_RD[op] ? rd : rt;

  assign hazard   = in_valid & (pend(rs) | (src2_used & pend(s2)));
  assign full     = wr & in_range(rd) & (cnt[rd[RA_W-1:0]] == CW'(MAX_INFL));
  assign in_ready = rst & ~hazard & ~full & ~flush & (~out_valid | out_ready);
  assign fire     = in_valid & in_ready;

  assign src1_val = read_reg(rs);
  assign src2_val = src2_used ? read_reg(s2) : '0;
  assign imm_val  = IMM8_MASK[op] ? {{(DATA_W-8){in_inst[7]}}, in_inst[7:0]}
                                  : {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};

  // Issue, write-back and flush-undo can all hit one register in the same cycle.
  always_comb begin
    up = '0;
    dn = '0;
    for (int r = 0; r < NREGS; r++) begin
      up = {1'b0, cnt[r]} + (CW+1)'(fire & wr & (rd == 4'(r)));
      dn = (CW+1)'(wb_en & (wb_reg == 4'(r)) & (cnt[r] != '0))
         + (CW+1)'(flush & out_valid & out_wr_en & (out_rd == 4'(r)));
      cnt_nxt[r] = (up > dn) ? CW'(up - dn) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= (r == SP_IDX) ? SP_RESET : '0;
        cnt[r]  <= '0;
      end
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_wr_en <= 1'b0;
      out_src1  <= '0;
      out_src2  <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      stall_cnt <= '0;
    end else begin
      if (wb_en && in_range(wb_reg)) regs[wb_reg[RA_W-1:0]] <= wb_data;
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
      if (fire) begin
        out_valid <= 1'b1;
        out_op    <= op;
        out_rd    <= rd;
        out_wr_en <= wr;
        out_src1  <= src1_val;
        out_src2  <= src2_val;
        out_imm   <= imm_val;
        out_pc    <= in_pc;
      end else if (out_ready || flush) begin
        out_valid <= 1'b0;
      end
      if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_id_issue_sb.sv
// tb/tb_id_issue_sb.sv - scoreboard bench for id_issue_sb against a behavioural issue model
module tb_id_issue_sb;
  localparam logic [15:0] WRM  = 16'h00FF;
  localparam logic [15:0] RTM  = 16'h000F;
  localparam logic [15:0] S2M  = 16'h0100;
  localparam logic [15:0] I8M  = 16'h00F0;
  localparam int          MAXI = 3;

  logic        clk, rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic        out_wr_en, hazard;
  logic [15:0] in_inst, in_pc, wb_data, out_src1, out_src2, out_imm, out_pc, stall_cnt;
  logic [3:0]  wb_reg, out_op, out_rd;

  id_issue_sb #(
    .DATA_W(16), .NREGS(16), .SP_IDX(15), .SP_RESET(16'hFFFF), .MAX_INFL(MAXI),
    .BYPASS(1'b1), .WR_MASK(WRM), .RT_MASK(RTM), .SRC2_RD(S2M), .IMM8_MASK(I8M)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
    .out_pc(out_pc), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        wr;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] imm;
    logic [15:0] pc;
  } ent_t;

  int          m_cnt [16];
  logic [15:0] m_reg [16];
  ent_t        m_slot;
  bit          m_slot_v;
  int          m_stall;
  ent_t        q [$];

  bit   e_hz, e_rdy, e_fire;
  ent_t e_ent;
  int   n_tests, n_fail;
  bit   mon_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int rt);
    return 16'((op << 12) | (rd << 8) | (rs << 4) | rt);
  endfunction

  // A register is busy while writes are outstanding, unless the last one retires right now.
  function automatic bit m_pend(input int r);
    return (m_cnt[r] > 0) && !(wb_en && (int'(wb_reg) == r) && (m_cnt[r] == 1));
  endfunction

  function automatic logic [15:0] m_read(input int r);
    return (wb_en && (int'(wb_reg) == r)) ? wb_data : m_reg[r];
  endfunction

  task automatic compute_exp();
    int op, rd, rs, rt, s2, v;
    bit use2, full;
    op   = int'(in_inst[15:12]);
    rd   = int'(in_inst[11:8]);
    rs   = int'(in_inst[7:4]);
    rt   = int'(in_inst[3:0]);
    use2 = S2M[op] || RTM[op];
    s2   = S2M[op] ? rd : rt;
    e_hz   = in_valid && (m_pend(rs) || (use2 && m_pend(s2)));
    full   = WRM[op] && (m_cnt[rd] == MAXI);
    e_rdy  = rst && !e_hz && !full && !flush && (!m_slot_v || out_ready);
    e_fire = in_valid && e_rdy;
    if (I8M[op]) begin
      v = int'(in_inst[7:0]);
      if (v > 127) v -= 256;
    end else begin
      v = int'(in_inst[3:0]);
      if (v > 7) v -= 16;
    end
    e_ent.op  = in_inst[15:12];
    e_ent.rd  = in_inst[11:8];
    e_ent.wr  = WRM[op];
    e_ent.s1  = m_read(rs);
    e_ent.s2  = use2 ? m_read(s2) : 16'h0000;
    e_ent.imm = v[15:0];
    e_ent.pc  = in_pc;
  endtask

  task automatic model_update();
    int nc [16];
    if (!rst) begin
      for (int r = 0; r < 16; r++) begin
        m_cnt[r] = 0;
        m_reg[r] = (r == 15) ? 16'hFFFF : 16'h0000;
      end
      m_slot_v = 1'b0;
      m_stall  = 0;
      q.delete();
      return;
    end
    nc = m_cnt;
    if (e_fire && e_ent.wr) nc[e_ent.rd]++;
    if (wb_en && (m_cnt[wb_reg] > 0)) nc[wb_reg]--;
    if (flush && m_slot_v && m_slot.wr) nc[m_slot.rd]--;
    for (int r = 0; r < 16; r++) if (nc[r] < 0) nc[r] = 0;
    m_cnt = nc;
    if (wb_en) m_reg[wb_reg] = wb_data;
    if (in_valid && !e_rdy && (m_stall < 65535)) m_stall++;
    if (e_fire) begin
      m_slot   = e_ent;
      m_slot_v = 1'b1;
      q.push_back(e_ent);
    end else if (out_ready || flush) begin
      m_slot_v = 1'b0;
    end
  endtask

  task automatic drive(input bit r_, input bit v, input logic [15:0] inst, input bit fl,
                       input bit we, input int wr_, input logic [15:0] wd, input bit ordy);
    rst       = r_;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = 16'($urandom);
    flush     = fl;
    wb_en     = we;
    wb_reg    = 4'(wr_);
    wb_data   = wd;
    out_ready = ordy;
    compute_exp();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input bit r_, input bit v, input logic [15:0] inst, input bit fl,
                     input bit we, input int wr_, input logic [15:0] wd, input bit ordy);
    drive(r_, v, inst, fl, we, wr_, wd, ordy);
    step();
  endtask

  // Monitor: combinational predictions and the head of the issue queue, mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("hazard", {31'd0, hazard}, {31'd0, e_hz});
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_slot_v});
      if (m_slot_v) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL slot_queue: got empty expected one entry (t=%0t)", $time);
        end else begin
          chk("out_op", {28'd0, out_op}, {28'd0, q[0].op});
          chk("out_rd", {28'd0, out_rd}, {28'd0, q[0].rd});
          chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, q[0].wr});
          chk("out_src1", {16'd0, out_src1}, {16'd0, q[0].s1});
          chk("out_src2", {16'd0, out_src2}, {16'd0, q[0].s2});
          chk("out_imm", {16'd0, out_imm}, {16'd0, q[0].imm});
          chk("out_pc", {16'd0, out_pc}, {16'd0, q[0].pc});
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int pl [$];
    int wbr, rsf;
    bit rr, vv, fl, we, ordy;
    n_tests  = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    m_slot_v = 1'b0;
    m_stall  = 0;
    for (int r = 0; r < 16; r++) begin
      m_cnt[r] = 0;
      m_reg[r] = 16'h0000;
    end

    // reset, then the stack pointer reads back its reset value
    cyc(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1);
    mon_en = 1'b1;
    cyc(0, 0, 16'h0000, 0, 1, 15, 16'h1234, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    cyc(1, 1, ins(0, 1, 15, 0), 0, 0, 0, 16'h0000, 1);
    chk("sp_reset_src1", {16'd0, out_src1}, 32'h0000FFFF);

    // RAW on r3, released by a bypassed write-back
    cyc(1, 1, ins(0, 3, 0, 0), 0, 1, 1, 16'h1111, 1);
    drive(1, 1, ins(1, 4, 0, 3), 0, 0, 0, 16'h0000, 1);
    chk("raw_hazard", {31'd0, hazard}, 32'd1);
    chk("raw_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    drive(1, 1, ins(1, 4, 0, 3), 0, 1, 3, 16'hBEEF, 1);
    chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("raw_bypass_src2", {16'd0, out_src2}, 32'h0000BEEF);

    // backpressure for three cycles
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, ins(0, 6, 0, 0), 0, 0, 0, 16'h0000, 0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("bp_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    drive(1, 1, ins(0, 6, 0, 0), 0, 0, 0, 16'h0000, 1);
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_issued_rd", {28'd0, out_rd}, 32'd6);

    // outstanding-write saturation on r5
    for (int k = 0; k < 3; k++) cyc(1, 1, ins(0, 5, 0, 0), 0, 0, 0, 16'h0000, 1);
    drive(1, 1, ins(0, 5, 0, 0), 0, 0, 0, 16'h0000, 1);
    chk("sat_full", {31'd0, in_ready}, 32'd0);
    chk("sat_no_hazard", {31'd0, hazard}, 32'd0);
    step();
    drive(1, 1, ins(0, 5, 0, 0), 0, 1, 5, 16'h5555, 1);
    chk("sat_full_during_wb", {31'd0, in_ready}, 32'd0);
    step();
    drive(1, 1, ins(0, 5, 0, 0), 0, 0, 0, 16'h0000, 1);
    chk("sat_release", {31'd0, in_ready}, 32'd1);
    step();

    // flush undoes the pending write of the dropped slot
    cyc(1, 1, ins(0, 2, 0, 0), 0, 0, 0, 16'h0000, 1);
    cyc(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0);
    chk("flush_drop", {31'd0, out_valid}, 32'd0);
    drive(1, 1, ins(0, 8, 2, 0), 0, 0, 0, 16'h0000, 1);
    chk("flush_undo_hazard", {31'd0, hazard}, 32'd0);
    chk("flush_undo_ready", {31'd0, in_ready}, 32'd1);
    step();

    // issue and write-back on r7 together, then write-back at zero count
    cyc(1, 1, ins(0, 7, 0, 0), 0, 0, 0, 16'h0000, 1);
    cyc(1, 1, ins(0, 7, 0, 0), 0, 1, 7, 16'h7777, 1);
    drive(1, 1, ins(0, 9, 7, 0), 0, 0, 0, 16'h0000, 1);
    chk("simul_cnt_kept", {31'd0, hazard}, 32'd1);
    step();
    cyc(1, 0, 16'h0000, 0, 1, 7, 16'h0007, 1);
    cyc(1, 0, 16'h0000, 0, 1, 7, 16'h0008, 1);
    cyc(1, 1, ins(0, 7, 0, 0), 0, 0, 0, 16'h0000, 1);
    drive(1, 1, ins(0, 9, 7, 0), 0, 0, 0, 16'h0000, 1);
    chk("no_underflow_hazard", {31'd0, hazard}, 32'd1);
    step();
    drive(1, 1, ins(0, 9, 7, 0), 0, 1, 7, 16'h0123, 1);
    chk("no_underflow_release", {31'd0, in_ready}, 32'd1);
    step();
    chk("no_underflow_src1", {16'd0, out_src1}, 32'h00000123);

    // random traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      rr   = !((i == 700) || (i == 701));
      vv   = ($urandom % 4) != 0;
      fl   = ($urandom % 10) == 0;
      ordy = ($urandom % 10) < 7;
      we   = ($urandom % 5) < 2;
      pl.delete();
      for (int r = 0; r < 16; r++) if (m_cnt[r] > 0) pl.push_back(r);
      if ((pl.size() != 0) && (($urandom % 4) != 0)) wbr = pl[$urandom % pl.size()];
      else wbr = $urandom_range(0, 15);
      rsf = (($urandom % 8) == 0) ? 15 : $urandom_range(0, 7);
      cyc(rr, vv, ins($urandom_range(0, 15), $urandom_range(0, 7), rsf, $urandom_range(0, 7)),
          fl, we, wbr, 16'($urandom), ordy);
    end
    for (int k = 0; k < 4; k++) cyc(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
